// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit controller: register map,
// CTRL/STATUS bit positions and the default channel width.
package i2s_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_DATA   = 2'd2;
   localparam logic [1:0] ADDR_CLKDIV = 2'd3;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_FLUSH_BIT = 1;
   localparam int CTRL_THR_LSB   = 8;

   localparam int ST_FULL_BIT     = 8;
   localparam int ST_EMPTY_BIT    = 9;
   localparam int ST_UNDERRUN_BIT = 10;
   localparam int ST_OVERFLOW_BIT = 11;

   localparam int SAMPLE_W_DEF = 16;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with push, pop, flush, full/empty and level.
// Ports: clk_i, rst_ni, push_i/wdata_i, pop_i/rdata_o, flush_i, full_o, empty_o, level_o.
module i2s_sample_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == LW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign level_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal when a pop frees the slot this cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)
         cnt_d = '0;
      else if (do_push & ~do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (do_pop & ~do_push)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push & ~flush_i)
         mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// Avalon-MM I2S transmitter: register file, sample FIFO, BCLK divider and
// MSB-first serializer with one-BCLK data delay. Ports: avs_s0_* slave,
// i2s_bclk/i2s_lrclk/i2s_sdata codec pins; irq only with I2S_TX_IRQ_EN.
module i2s_tx_ctrl
   import i2s_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int DIV_W      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_s0_address,
   input  logic        avs_s0_read,
   input  logic        avs_s0_write,
   output logic        avs_s0_waitrequest,
   output logic [31:0] avs_s0_readdata,
   input  logic [31:0] avs_s0_writedata,
   output logic        i2s_bclk,
   output logic        i2s_lrclk,
   output logic        i2s_sdata
`ifdef I2S_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int FW = 2 * SAMPLE_W;
   localparam int BW = $clog2(FW);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic             en_q, en_d;
   logic [DIV_W-1:0] clkdiv_q, div_act_q, divcnt_q;
   logic             bclk_q;
   logic [BW-1:0]    bitcnt_q;
   logic [FW-1:0]    shift_q;
   logic             underrun_q, overflow_q, rd_pend_q;
   logic [31:0]      rdata_q, rd_mux;
   logic             wr_ctrl, wr_status, wr_data, wr_clkdiv, flush;
   logic             run, tick, fall, wrap, pop, push, stall, ovf_set;
   logic             rd_first, full, empty;
   logic [LW-1:0]    level;
   logic [FW-1:0]    head;
`ifdef I2S_TX_IRQ_EN
   logic [7:0]       thresh_q;
   logic             irq_q;
`endif

   assign wr_ctrl   = avs_s0_write & (avs_s0_address == ADDR_CTRL);
   assign wr_status = avs_s0_write & (avs_s0_address == ADDR_STATUS);
   assign wr_data   = avs_s0_write & (avs_s0_address == ADDR_DATA);
   assign wr_clkdiv = avs_s0_write & (avs_s0_address == ADDR_CLKDIV);

   assign en_d  = wr_ctrl ? avs_s0_writedata[CTRL_EN_BIT] : en_q;
   assign flush = wr_ctrl & avs_s0_writedata[CTRL_FLUSH_BIT];

   // Stream stops the same cycle enable is cleared so pins idle next cycle.
   assign run  = en_q & en_d;
   assign tick = run & (divcnt_q == div_act_q);
   assign fall = tick & bclk_q;
   assign wrap = fall & (bitcnt_q == BW'(FW - 1));
   assign pop  = wrap & ~empty;

   // Full + enabled: hold the master until the frame-start pop frees a slot.
   assign stall   = wr_data & full & en_q & ~pop;
   assign push    = wr_data & (~full | pop);
   assign ovf_set = wr_data & full & ~en_q;

   assign rd_first           = avs_s0_read & ~rd_pend_q;
   assign avs_s0_waitrequest = rd_first | stall;
   assign avs_s0_readdata    = rdata_q;

   assign i2s_bclk  = bclk_q;
   assign i2s_sdata = shift_q[FW-1];
   assign i2s_lrclk = (bitcnt_q >= BW'(SAMPLE_W - 1)) &
                      (bitcnt_q <= BW'(FW - 2));

   i2s_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW),
      .LW    (LW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push),
      .wdata_i (avs_s0_writedata[FW-1:0]),
      .pop_i   (pop),
      .flush_i (flush),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   always_comb begin
      rd_mux = '0;
      case (avs_s0_address)
         ADDR_CTRL: begin
            rd_mux[CTRL_EN_BIT] = en_q;
`ifdef I2S_TX_IRQ_EN
            rd_mux[CTRL_THR_LSB +: 8] = thresh_q;
`endif
         end
         ADDR_STATUS: begin
            rd_mux[7:0]             = 8'(level);
            rd_mux[ST_FULL_BIT]     = full;
            rd_mux[ST_EMPTY_BIT]    = empty;
            rd_mux[ST_UNDERRUN_BIT] = underrun_q;
            rd_mux[ST_OVERFLOW_BIT] = overflow_q;
         end
         ADDR_CLKDIV: rd_mux[DIV_W-1:0] = clkdiv_q;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q       <= 1'b0;
         clkdiv_q   <= '0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         en_q      <= en_d;
         rd_pend_q <= rd_first;
         if (rd_first)
            rdata_q <= rd_mux;
         if (wr_clkdiv)
            clkdiv_q <= avs_s0_writedata[DIV_W-1:0];
         if (wrap & empty)
            underrun_q <= 1'b1;
         else if (wr_status & avs_s0_writedata[ST_UNDERRUN_BIT])
            underrun_q <= 1'b0;
         if (ovf_set)
            overflow_q <= 1'b1;
         else if (wr_status & avs_s0_writedata[ST_OVERFLOW_BIT])
            overflow_q <= 1'b0;
      end
   end

   // Divider and serializer. A new CLKDIV is sampled only at a divcnt wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divcnt_q  <= '0;
         div_act_q <= '0;
         bclk_q    <= 1'b0;
         bitcnt_q  <= BW'(FW - 1);
         shift_q   <= '0;
      end else if (!run) begin
         divcnt_q  <= '0;
         div_act_q <= clkdiv_q;
         bclk_q    <= 1'b0;
         bitcnt_q  <= BW'(FW - 1);
         shift_q   <= '0;
      end else if (tick) begin
         divcnt_q  <= '0;
         div_act_q <= clkdiv_q;
         bclk_q    <= ~bclk_q;
         if (fall) begin
            bitcnt_q <= wrap ? '0 : bitcnt_q + 1'b1;
            if (wrap)
               shift_q <= empty ? '0 : head;
            else
               shift_q <= {shift_q[FW-2:0], 1'b0};
         end
      end else begin
         divcnt_q <= divcnt_q + 1'b1;
      end
   end

`ifdef I2S_TX_IRQ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         thresh_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ctrl)
            thresh_q <= avs_s0_writedata[CTRL_THR_LSB +: 8];
         irq_q <= (en_q & (8'(level) <= thresh_q)) | underrun_q | overflow_q;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: register access, frame timing,
// underrun/overflow, write stall, flush, reset and optional irq.
module tb_i2s_tx_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        bclk, lrclk, sdata;
`ifdef I2S_TX_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;

   int   rise_cyc [64];
   logic lr_s [64];
   logic sd_s [64];
   int   nrise;
   logic sd_or;

   i2s_tx_ctrl dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .avs_s0_address     (address),
      .avs_s0_read        (read),
      .avs_s0_write       (write),
      .avs_s0_waitrequest (waitrequest),
      .avs_s0_readdata    (readdata),
      .avs_s0_writedata   (writedata),
      .i2s_bclk           (bclk),
      .i2s_lrclk          (lrclk),
      .i2s_sdata          (sdata)
`ifdef I2S_TX_IRQ_EN
      ,
      .irq                (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d,
                     output int stalls);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1;
      #1;
      stalls = 0;
      while (waitrequest && stalls < 1000) begin
         @(negedge clk); #1;
         stalls++;
      end
      if (stalls >= 1000) begin
         checks++; errors++;
         $display("FAIL wr_timeout observed=stalled expected=accepted");
      end
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic wr0(input logic [1:0] a, input logic [31:0] d);
      int s;
      wr(a, d, s);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d,
                     output logic w1, output logic w2);
      @(negedge clk);
      address = a; read = 1'b1;
      #1; w1 = waitrequest;
      @(negedge clk);
      #1; w2 = waitrequest; d = readdata;
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] a,
                        input logic [31:0] e);
      logic [31:0] d;
      logic w1, w2;
      rd(a, d, w1, w2);
      chk(tag, d, e);
   endtask

   task automatic capture(input int maxcyc, input int want);
      logic prev;
      prev  = bclk;
      nrise = 0;
      sd_or = 1'b0;
      for (int c = 0; c < maxcyc && nrise < want; c++) begin
         @(negedge clk);
         if (bclk && !prev) begin
            rise_cyc[nrise] = c;
            lr_s[nrise]     = lrclk;
            sd_s[nrise]     = sdata;
            nrise++;
         end
         sd_or = sd_or | sdata;
         prev  = bclk;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic        w1, w2;
      logic [15:0] left, right;
      int          s, n;

      repeat (3) @(negedge clk);
      chk("rst_pins", {28'd0, bclk, lrclk, sdata, waitrequest}, 32'h0);
      chk("rst_rdata", readdata, 32'h0);
      reset_n = 1'b1;

      rd(2'd1, d, w1, w2);
      chk("rd_wait1", {31'd0, w1}, 32'd1);
      chk("rd_wait2", {31'd0, w2}, 32'd0);
      chk("rst_status", d, 32'h0000_0200);

      // Single frame, CLKDIV=1
      wr0(2'd3, 32'd1);
      wr0(2'd2, 32'hA5A5_3C3C);
      wr0(2'd0, 32'h1);
      capture(300, 34);
      chk("f_rises", nrise, 34);
      chk("f_first_rise", rise_cyc[0], 2);
      chk("f_period", rise_cyc[1] - rise_cyc[0], 4);
      chk("f_period_mid", rise_cyc[20] - rise_cyc[19], 4);
      left = '0; right = '0;
      for (int r = 1; r <= 16; r++) left = {left[14:0], sd_s[r]};
      for (int r = 17; r <= 32; r++) right = {right[14:0], sd_s[r]};
      chk("f_left", {16'd0, left}, 32'h0000_A5A5);
      chk("f_right", {16'd0, right}, 32'h0000_3C3C);
      chk("f_lr_b14", {31'd0, lr_s[15]}, 32'd0);
      chk("f_lr_b15", {31'd0, lr_s[16]}, 32'd1);
      chk("f_lr_b30", {31'd0, lr_s[31]}, 32'd1);
      chk("f_lr_b31", {31'd0, lr_s[32]}, 32'd0);

      // Underrun
      wr0(2'd0, 32'h0);
      chk("dis_pins", {29'd0, bclk, lrclk, sdata}, 32'h0);
      wr0(2'd1, 32'hC00);
      rdchk("st_cleared", 2'd1, 32'h0000_0200);
      wr0(2'd0, 32'h1);
      capture(300, 34);
      chk("ur_sdata", {31'd0, sd_or}, 32'd0);
      rdchk("st_underrun", 2'd1, 32'h0000_0600);
      wr0(2'd0, 32'h0);
      wr0(2'd1, 32'h400);
      rdchk("st_ur_clr", 2'd1, 32'h0000_0200);

      // Full FIFO stall while enabled, CLKDIV=3
      wr0(2'd3, 32'd3);
      for (int i = 0; i < 8; i++) wr0(2'd2, 32'h1000_0000 + i);
      rdchk("st_full", 2'd1, 32'h0000_0108);
      wr0(2'd0, 32'h1);
      wr(2'd2, 32'h1000_0008, s);
      chk("stall_cycles", s, 7);
      rdchk("st_after_stall", 2'd1, 32'h0000_0108);

      // Overflow with enable clear, then flush
      wr0(2'd0, 32'h0);
      wr0(2'd0, 32'h2);
      rdchk("st_flush1", 2'd1, 32'h0000_0200);
      rdchk("ctrl_rd", 2'd0, 32'h0);
      for (int i = 0; i < 8; i++) wr0(2'd2, 32'h2000_0000 + i);
      wr(2'd2, 32'h2000_0008, s);
      chk("ovf_nostall", s, 0);
      rdchk("st_ovf", 2'd1, 32'h0000_0908);
      wr0(2'd0, 32'h2);
      rdchk("st_flush2", 2'd1, 32'h0000_0A00);
      rdchk("data_rd", 2'd2, 32'h0);
      rdchk("clkdiv_rd", 2'd3, 32'd3);
      wr0(2'd1, 32'hC00);
      rdchk("st_clr2", 2'd1, 32'h0000_0200);

`ifdef I2S_TX_IRQ_EN
      wr0(2'd0, 32'h200);
      rdchk("ctrl_thr", 2'd0, 32'h0000_0200);
      for (int i = 0; i < 4; i++) wr0(2'd2, 32'h3000_0000 + i);
      @(negedge clk);
      chk("irq_off", {31'd0, irq}, 32'd0);
      wr0(2'd0, 32'h201);
      @(negedge clk);
      chk("irq_lvl4", {31'd0, irq}, 32'd0);
      n = 0;
      while (!irq && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("irq_rise", {31'd0, irq}, 32'd1);
      rdchk("irq_level", 2'd1, 32'h0000_0002);
      wr0(2'd0, 32'h0);
`else
      wr0(2'd0, 32'h200);
      rdchk("ctrl_thr_ign", 2'd0, 32'h0);
      n = 0;
`endif

      // Asynchronous reset mid-frame
      wr0(2'd3, 32'd1);
      wr0(2'd2, 32'hFFFF_FFFF);
      wr0(2'd0, 32'h1);
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_pins", {28'd0, bclk, lrclk, sdata, waitrequest}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      rdchk("mid_rst_status", 2'd1, 32'h0000_0200);
      rdchk("mid_rst_clkdiv", 2'd3, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx_ctrl.md
Name: i2s_tx_ctrl

Overview:
- Avalon-MM slave controller that sequences an I2S transmit path.
- Software writes packed stereo samples into a small FIFO.
- The block generates BCLK/LRCLK from the system clock and serializes samples MSB-first in standard I2S format (one-BCLK data delay).
- Sits between the Avalon interconnect and the codec pins; handles flow control, underrun/overflow reporting and clock configuration.

Parameters:
- FIFO_DEPTH, 8: sample FIFO entries; power of two, 2..64.
- SAMPLE_W, 16: bits per channel; a frame is 2*SAMPLE_W BCLKs.
- DIV_W, 8: width of the BCLK divider register.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- avs_s0_address, input, 2: register select (0 CTRL, 1 STATUS, 2 DATA, 3 CLKDIV).
- avs_s0_read, input, 1: read strobe.
- avs_s0_write, input, 1: write strobe.
- avs_s0_waitrequest, output, 1: stall.
- avs_s0_readdata, output, 32: read data.
- avs_s0_writedata, input, 32: write data.
- i2s_bclk, output, 1: bit clock.
- i2s_lrclk, output, 1: word select; 0 = left, 1 = right.
- i2s_sdata, output, 1: serial data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, except avs_s0_waitrequest = 1 only while a read is in its first cycle. Internal reset values:
  - CTRL = 0, CLKDIV = 0, FIFO empty, sticky flags 0.
  - bitcnt = 2*SAMPLE_W-1, shift register = 0.
- Registers:
  - CTRL: bit0 enable (R/W); bit1 flush (write-1, self-clearing, reads 0).
  - STATUS (read): [7:0] level; bit8 full; bit9 empty; bit10 underrun (sticky); bit11 overflow (sticky). Writing STATUS with bit10/bit11 = 1 clears that flag.
  - DATA: write-only; {left[31:16], right[15:0]} for SAMPLE_W = 16. Reads return 0.
  - CLKDIV: [DIV_W-1:0], R/W.
- Reads: two cycles. Cycle 1: waitrequest = 1, readdata registered. Cycle 2: waitrequest = 0, readdata valid. Back-to-back reads each take two cycles.
- Writes: zero wait state, except a DATA write while FIFO full and enable = 1. That write holds waitrequest = 1 until the serializer pops, then is accepted in the same cycle the slot frees.
- DATA write while full and enable = 0: accepted, data dropped, overflow set.
- Divider: while enable = 1, divcnt counts 0..CLKDIV. At the terminal count, i2s_bclk toggles and divcnt returns to 0. BCLK period = 2*(CLKDIV+1) clk cycles.
- Falling-edge actions (cycle i2s_bclk toggles 1 -> 0):
  - bitcnt increments modulo 2*SAMPLE_W.
  - Shift register shifts left; i2s_sdata = shift MSB.
- Frame load: on the falling edge where bitcnt wraps to 0:
  - If FIFO non-empty: pop and load the word.
  - Else: load 0 and set underrun.
- Word select: i2s_lrclk = 1 for bitcnt in SAMPLE_W-1 .. 2*SAMPLE_W-2, else 0. This places LRCLK one BCLK ahead of each channel MSB.
- Simultaneous push and pop: level unchanged. Flush concurrent with pop: flush wins, level = 0.
- Clearing enable: i2s_bclk, i2s_lrclk and i2s_sdata go 0 next cycle; divcnt = 0; bitcnt = 2*SAMPLE_W-1; FIFO contents kept.
- Setting enable: first BCLK rising edge occurs CLKDIV+1 cycles later.
- CLKDIV written mid-stream: takes effect at the next divcnt wrap.
- Reset mid-frame: immediate return to reset values; any stalled write is abandoned.

Optional Feature:
- Macro I2S_TX_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and CTRL[15:8] threshold.
  - irq = enable & (level <= threshold) | underrun | overflow, registered; reset value 0.
- Undefined: no irq port; CTRL[15:8] reads 0 and ignores writes.

Decomposition:
- Package i2s_pkg:
  - Register address constants (ADDR_CTRL = 0, ADDR_STATUS = 1, ADDR_DATA = 2, ADDR_CLKDIV = 3).
  - STATUS/CTRL bit-position constants.
  - Default SAMPLE_W.
- Sub-module i2s_sample_fifo: synchronous FIFO with push, pop, flush, full, empty and level.
- Divider, serializer and register file stay in i2s_tx_ctrl.

Test Plan:
- Reset, then read STATUS -> waitrequest 1 then 0; readdata = 0x00000200 (empty, level 0).
- CLKDIV = 1, write DATA 0xA5A5_3C3C, enable -> BCLK period 4 clk; LRCLK falls one BCLK before bit15 of 0xA5A5 appears; right MSB follows LRCLK rise by one BCLK.
- Enable with empty FIFO -> sdata stays 0 for the whole frame; STATUS bit10 = 1; write STATUS 0x400 -> bit10 = 0.
- Fill 8 words with enable = 1, CLKDIV = 3, write a 9th -> waitrequest held high until the frame-start pop, then accepted; level = 8.
- enable = 0, fill 8, write 9th -> no stall, overflow bit11 = 1, level 8; flush -> level 0, empty = 1.
- With I2S_TX_IRQ_EN defined, threshold = 2, enable, 4 words -> irq asserts when level drops to 2.
